// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide engine owning the architectural HI/LO registers.
// One product/quotient bit per cycle, followed by a sign-fixup commit cycle.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             z,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state, state_n;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic [WIDTH:0]       rem;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_res, neg_rem, is_div;

  logic                 valid_op, sgn_op, div_op, last;
  logic [WIDTH-1:0]     abs1, abs2;
  logic [WIDTH:0]       psum, shl, diff;
  logic                 take;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo;

  always_comb begin
    valid_op = (op[3:2] == 2'b11);
    sgn_op   = op[1];
    div_op   = op[0];
    abs1     = (sgn_op && in1[WIDTH-1]) ? -in1 : in1;
    abs2     = (sgn_op && in2[WIDTH-1]) ? -in2 : in2;
    last     = (cnt == CNT_W'(WIDTH - 1));
    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    // Divide: acc[WIDTH-1:0] shifts the dividend out and the quotient in
    shl      = {rem[WIDTH-1:0], acc[WIDTH-1]};
    diff     = shl - {1'b0, opb};
    take     = (shl >= {1'b0, opb});
    prod     = neg_res ? -acc : acc;
    quo      = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start && valid_op) state_n = div_op ? DIV : MUL;
      MUL:  if (last) state_n = FIX;
      DIV:  begin
        if (opb == '0)  state_n = IDLE;
        else if (last)  state_n = FIX;
      end
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign z    = (hi == '0) && (lo == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      dz      <= 1'b0;
      acc     <= '0;
      opb     <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      is_div  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start && valid_op) begin
            acc     <= {{WIDTH{1'b0}}, (div_op ? abs1 : abs2)};
            opb     <= div_op ? abs2 : abs1;
            rem     <= '0;
            cnt     <= '0;
            neg_res <= sgn_op && (in1[WIDTH-1] ^ in2[WIDTH-1]);
            neg_rem <= sgn_op && in1[WIDTH-1];
            is_div  <= div_op;
          end
        end
        MUL: begin
          acc <= {psum, acc[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        DIV: begin
          if (opb == '0) begin
            hi   <= '0;
            lo   <= '0;
            dz   <= 1'b1;
            done <= 1'b1;
          end else begin
            rem             <= take ? diff : shl;
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], take};
            cnt             <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= WIDTH'(neg_rem ? -rem : rem);
            lo <= quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          dz   <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed edge cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, wr_hi, wr_lo;
  logic [3:0]  op;
  logic [31:0] in1, in2, wdata;
  logic        busy, done, dz, z;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  logic [31:0] mhi, mlo;
  logic        mdz;

  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .z(z), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    edz = 1'b0;
    if (o[0]) begin
      if (b == 32'd0) begin
        eh = '0; el = '0; edz = 1'b1;
      end else begin
        if (o[1]) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
        else      begin sa = longint'({32'b0, a}); sb = longint'({32'b0, b}); end
        q = sa / sb;
        r = sa % sb;
        el = q[31:0];
        eh = r[31:0];
      end
    end else begin
      if (o[1]) p = longint'($signed(a)) * longint'($signed(b));
      else      p = {32'b0, a} * {32'b0, b};
      eh = p[63:32];
      el = p[31:0];
    end
  endfunction

  // mode 0: plain, 1: restart + MTHI attempt while busy, 2: MTHI on the accepting edge
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [31:0] eh, el;
    logic        edz;
    int          lat, exp_lat;
    model(o, a, b, eh, el, edz);
    exp_lat = (o[0] && b == 32'd0) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; op = o; in1 = a; in2 = b;
    if (mode == 2) begin wr_hi = 1'b1; wdata = 32'h1234_5678; end
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0;
    in1 = $urandom; in2 = $urandom; op = 4'($urandom);
    check("busy_after_accept", busy, 1);
    if (mode == 2) begin
      check("mthi_same_edge_as_start", hi, 32'h1234_5678);
      mhi = 32'h1234_5678;
    end
    lat = 0;
    while (lat < 40) begin
      if (mode == 1 && lat == 5) begin
        start = 1'b1; op = 4'b1100; in1 = $urandom; in2 = $urandom;
        wr_hi = 1'b1; wdata = 32'h0000_00A5;
      end
      @(posedge clk); #1;
      lat++;
      start = 1'b0; wr_hi = 1'b0;
      if (done) break;
      if (mode == 1 && lat == 6) check("mthi_ignored_busy", hi, mhi);
    end
    check("latency", lat, exp_lat);
    check("hi", hi, eh);
    check("lo", lo, el);
    check("dz", dz, edz);
    check("z", z, (eh == 0 && el == 0));
    check("busy_after_done", busy, 0);
    mhi = eh; mlo = el; mdz = edz;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    int          sel;

    rst_n = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = '0; in1 = '0; in2 = '0; wdata = '0;
    mhi = '0; mlo = '0; mdz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", dz, 0);
    check("rst_z", z, 1);
    @(negedge clk); rst_n = 1'b1;

    // MTHI and MTLO together while idle
    @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_00A5;
    @(posedge clk); #1; wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthi_both", hi, 32'hA5);
    check("mtlo_both", lo, 32'hA5);
    check("z_after_mt", z, 0);
    mhi = 32'hA5; mlo = 32'hA5;

    // invalid op code is ignored
    @(negedge clk); start = 1'b1; op = 4'b0101; in1 = 32'd3; in2 = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    check("invalid_op_busy", busy, 0);
    check("invalid_op_hi", hi, mhi);

    // reset in the middle of a multiply aborts it
    @(negedge clk); start = 1'b1; op = 4'b1100; in1 = 32'd7; in2 = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      check("no_done_mid_mul", done, 0);
    end
    rst_n = 1'b0;
    #1;
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst_n = 1'b1;
    mhi = '0; mlo = '0; mdz = 1'b0;

    run_op(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op(4'b1110, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(4'b1110, 32'h8000_0000, 32'h8000_0000, 2);
    run_op(4'b1111, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(4'b1101, 32'd100, 32'd7, 0);
    run_op(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(4'b1101, 32'd5, 32'd0, 0);

    // dz holds across an idle MTLO
    @(negedge clk); wr_lo = 1'b1; wdata = 32'h77;
    @(posedge clk); #1; wr_lo = 1'b0;
    check("mtlo_idle", lo, 32'h77);
    check("dz_holds", dz, 1);

    run_op(4'b1100, 32'd2, 32'd3, 0);
    run_op(4'b1111, 32'd9, 32'd0, 0);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      ro  = {2'b11, 2'($urandom_range(0, 3))};
      ra  = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'($urandom_range(0, 20)) : $urandom;
      sel = $urandom_range(0, 7);
      rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
            (sel == 2) ? 32'($urandom_range(1, 9)) : $urandom;
      run_op(ro, ra, rb, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
